// File: rtl/kv_cache_pkt_mem.sv
// kv_cache_pkt_mem: KV-cache storage made of CACHE_PKT_NUM packets, each a row
// of CACHE_NUM byte-lane SRAM banks of depth CACHE_DEPTH. The active user
// selects one packet for every read and write. Per-bank power requests gate
// access, and each bank reports readiness on mpr.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   cache_addr            : [ROW_W-1:0] row, upper bits lane (byte mode only)
//   cache_ren / _wen      : read / write strobes (write wins when both are set)
//   cache_wdata           : write line; byte mode uses cache_wdata[LANE_W-1:0]
//   cache_wdata_byte_flag : 0 = whole line, 1 = single lane
//   cache_rdata           : registered read line, one cycle latency
//   usr_cfg               : user config, only user_id is used
//   sleep/deepslp/shutoff : per-bank power requests [pkt][bank]
//   bc1, bc2              : macro bias controls, no functional effect
//   mpr                   : per-bank power-ready [pkt][bank]

package kv_cache_pkg;
  localparam int UID_W = 8;

  typedef struct packed {
    logic [UID_W-1:0] user_id;
    logic [15:0]      user_token_cnt;
    logic             user_kv_cache_not_full;
    logic             user_first_token_flag;
  } USER_CONFIG;
endpackage

// One byte-lane bank: storage, per-row valid bits and the wake sequencer.
module kv_cache_bank #(
  parameter int LANE_W     = 8,
  parameter int DEPTH      = 256,
  parameter int ROW_W      = 8,
  parameter int WAKE_SLEEP = 1,
  parameter int WAKE_DEEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sleep,
  input  logic              deepslp,
  input  logic              shutoff,
  input  logic              wr_req,
  input  logic [ROW_W-1:0]  row,
  input  logic [LANE_W-1:0] wdata,
  output logic              mpr,
  output logic              acc,
  output logic [LANE_W-1:0] rd_lane
);
  localparam int WMAX  = (WAKE_DEEP > WAKE_SLEEP) ? WAKE_DEEP : WAKE_SLEEP;
  localparam int CNT_W = $clog2(WMAX + 1);

  logic              lp, slp_only, mpr_q, we;
  logic [CNT_W-1:0]  cnt, cnt_nxt, wake_tgt;
  logic [LANE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  assign lp       = sleep | deepslp | shutoff;
  // a request blocks access in the very cycle it appears, before mpr drops
  assign acc      = mpr_q & ~lp;
  assign we       = wr_req & acc;
  assign cnt_nxt  = cnt + 1'b1;
  assign wake_tgt = slp_only ? CNT_W'(WAKE_SLEEP) : CNT_W'(WAKE_DEEP);
  assign mpr      = mpr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mpr_q    <= 1'b0;
      cnt      <= '0;
      slp_only <= 1'b0;
    end else if (lp) begin
      mpr_q    <= 1'b0;
      cnt      <= '0;
      // only a plain sleep gets the short wake time
      slp_only <= sleep & ~deepslp & ~shutoff;
    end else if (!mpr_q) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == wake_tgt) mpr_q <= 1'b1;
    end
  end

  // shutoff loses contents; the valid bits model that loss
  always_ff @(posedge clk) begin
    if (rst || shutoff) vld <= '0;
    else if (we)        vld[row] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
  end

  assign rd_lane = vld[row] ? mem[row] : '0;
endmodule

module kv_cache_pkt_mem
  import kv_cache_pkg::*;
#(
  parameter int IDATA_WIDTH      = 64,
  parameter int ODATA_BIT        = 64,
  parameter int CACHE_NUM        = 8,
  parameter int CACHE_PKT_NUM    = 2,
  parameter int CACHE_DEPTH      = 256,
  parameter int CACHE_ADDR_WIDTH = $clog2(CACHE_NUM) + $clog2(CACHE_DEPTH),
  parameter int USER_NUM         = 4,
  parameter int WAKE_SLEEP       = 1,
  parameter int WAKE_DEEP        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [CACHE_ADDR_WIDTH-1:0]             cache_addr,
  input  logic                                    cache_ren,
  output logic [ODATA_BIT-1:0]                    cache_rdata,
  input  logic                                    cache_wen,
  input  logic [IDATA_WIDTH-1:0]                  cache_wdata,
  input  logic                                    cache_wdata_byte_flag,
  input  USER_CONFIG                              usr_cfg,
  input  logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0] sleep,
  input  logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0] deepslp,
  input  logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0] shutoff,
  input  logic                                    bc1,
  input  logic                                    bc2,
  output logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0] mpr
);
  localparam int LANE_W = IDATA_WIDTH / CACHE_NUM;
  localparam int ROW_W  = $clog2(CACHE_DEPTH);
  localparam int LIDX_W = CACHE_ADDR_WIDTH - ROW_W;
  localparam int UPP    = USER_NUM / CACHE_PKT_NUM;

  logic [ROW_W-1:0]                                   row;
  logic [LIDX_W-1:0]                                  lane;
  logic [UID_W-1:0]                                   pkt_idx;
  logic [CACHE_PKT_NUM-1:0]                           sel;
  logic [CACHE_NUM-1:0]                               lane_hit;
  logic [CACHE_NUM-1:0][LANE_W-1:0]                   wr_lane;
  logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0]            acc_all;
  logic [CACHE_PKT_NUM-1:0][CACHE_NUM-1:0][LANE_W-1:0] rd_all;
  logic [CACHE_NUM-1:0]                               rd_acc;
  logic [CACHE_NUM-1:0][LANE_W-1:0]                   rd_val, rdata_q;
  logic                                               unused_ok;

  assign row     = cache_addr[ROW_W-1:0];
  assign lane    = cache_addr[CACHE_ADDR_WIDTH-1:ROW_W];
  assign pkt_idx = usr_cfg.user_id / UID_W'(UPP);

  // bias pins and the rest of the user config only reach the macros
  assign unused_ok = ^{bc1, bc2, usr_cfg.user_token_cnt,
                       usr_cfg.user_kv_cache_not_full, usr_cfg.user_first_token_flag};

  for (genvar p = 0; p < CACHE_PKT_NUM; p++) begin : g_sel
    // an out-of-range user selects no packet at all
    assign sel[p] = (pkt_idx == UID_W'(p));
  end

  for (genvar b = 0; b < CACHE_NUM; b++) begin : g_lane
    assign lane_hit[b] = ~cache_wdata_byte_flag | (lane == LIDX_W'(b));
    assign wr_lane[b]  = cache_wdata_byte_flag ? cache_wdata[LANE_W-1:0]
                                               : cache_wdata[b*LANE_W +: LANE_W];
  end

  for (genvar p = 0; p < CACHE_PKT_NUM; p++) begin : g_pkt
    for (genvar b = 0; b < CACHE_NUM; b++) begin : g_bank
      kv_cache_bank #(
        .LANE_W    (LANE_W),
        .DEPTH     (CACHE_DEPTH),
        .ROW_W     (ROW_W),
        .WAKE_SLEEP(WAKE_SLEEP),
        .WAKE_DEEP (WAKE_DEEP)
      ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .sleep  (sleep[p][b]),
        .deepslp(deepslp[p][b]),
        .shutoff(shutoff[p][b]),
        .wr_req (cache_wen & sel[p] & lane_hit[b]),
        .row    (row),
        .wdata  (wr_lane[b]),
        .mpr    (mpr[p][b]),
        .acc    (acc_all[p][b]),
        .rd_lane(rd_all[p][b])
      );
    end
  end

  always_comb begin
    rd_acc = '0;
    rd_val = '0;
    for (int p = 0; p < CACHE_PKT_NUM; p++) begin
      if (sel[p]) begin
        rd_acc = rd_acc | acc_all[p];
        rd_val = rd_val | rd_all[p];
      end
    end
  end

  // lanes whose bank is not accessible keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cache_ren && !cache_wen) begin
      for (int b = 0; b < CACHE_NUM; b++)
        if (rd_acc[b]) rdata_q[b] <= rd_val[b];
    end
  end

  assign cache_rdata = rdata_q;
endmodule

// File: tb/tb_kv_cache_pkt_mem.sv
// tb_kv_cache_pkt_mem: table-driven power/reset vectors followed by scripted
// read/write sequences checked against a byte-level memory model through an
// expected-read queue.
module tb_kv_cache_pkt_mem;
  import kv_cache_pkg::*;

  localparam int N = 8, PN = 2, D = 256, AW = 11;

  logic              clk = 1'b0;
  logic              rst, ren, wen, bf, bc1, bc2;
  logic [AW-1:0]     addr;
  logic [63:0]       wdata, rdata;
  USER_CONFIG        usr_cfg;
  logic [1:0][7:0]   sleep, deepslp, shutoff, mpr;

  always #5 clk = ~clk;

  kv_cache_pkt_mem dut (
    .clk(clk), .rst(rst), .cache_addr(addr), .cache_ren(ren), .cache_rdata(rdata),
    .cache_wen(wen), .cache_wdata(wdata), .cache_wdata_byte_flag(bf),
    .usr_cfg(usr_cfg), .sleep(sleep), .deepslp(deepslp), .shutoff(shutoff),
    .bc1(bc1), .bc2(bc2), .mpr(mpr)
  );

  int checks = 0, failures = 0;

  logic [7:0]  mm [PN][N][D];
  bit          mv [PN][N][D];
  logic [7:0]  acc_m [PN];
  logic [63:0] rd_mdl = '0;
  logic [63:0] exp_q [$];

  typedef struct {
    bit          rst;
    logic [15:0] slp;
    logic [15:0] dsl;
    logic [15:0] exp_mpr;
  } vec_t;
  vec_t tv [23];

  function automatic vec_t v(bit r, logic [15:0] s, logic [15:0] d, logic [15:0] m);
    vec_t x;
    x.rst = r; x.slp = s; x.dsl = d; x.exp_mpr = m;
    return x;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic op(bit w, bit r, bit byt, logic [AW-1:0] a, logic [63:0] d);
    int p   = int'(usr_cfg.user_id) / 2;
    int row = int'(a[7:0]);
    int ln  = int'(a[10:8]);
    wen = w; ren = r; bf = byt; addr = a; wdata = d;
    if (w) begin
      for (int b = 0; b < N; b++)
        if (acc_m[p][b] && (!byt || b == ln)) begin
          mm[p][b][row] = byt ? d[7:0] : d[b*8 +: 8];
          mv[p][b][row] = 1'b1;
        end
    end else if (r) begin
      for (int b = 0; b < N; b++)
        if (acc_m[p][b]) rd_mdl[b*8 +: 8] = mv[p][b][row] ? mm[p][b][row] : 8'h00;
    end
    if (r) exp_q.push_back(rd_mdl);
    @(posedge clk); #1;
    if (r) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_queue got=empty exp=entry");
      end else begin
        chk($sformatf("rdata@%0h", a), rdata, exp_q.pop_front());
      end
    end
    wen = 1'b0; ren = 1'b0; bf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ren = 0; wen = 0; bf = 0; bc1 = 0; bc2 = 1; addr = '0; wdata = '0;
    sleep = '0; deepslp = '0; shutoff = '0;
    usr_cfg = '0; usr_cfg.user_token_cnt = 16'h1234; usr_cfg.user_first_token_flag = 1'b1;
    acc_m[0] = 8'h00; acc_m[1] = 8'h00;

    // reset, wake-after-reset, sleep wake, counter restart, sleep-only wake
    tv[0]  = v(1, 16'h0000, 16'hFF00, 16'h0000);
    tv[1]  = v(1, 16'h00FF, 16'hFFFF, 16'h0000);
    tv[2]  = v(1, 16'h0000, 16'hFF00, 16'h0000);
    tv[3]  = v(0, 16'h0000, 16'hFF00, 16'h0000);
    tv[4]  = v(0, 16'h0000, 16'hFF00, 16'h0000);
    tv[5]  = v(0, 16'h0000, 16'hFF00, 16'h0000);
    tv[6]  = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[7]  = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[8]  = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[9]  = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[10] = v(0, 16'h0001, 16'hFF00, 16'h00FE);
    tv[11] = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[12] = v(0, 16'h0000, 16'hFF02, 16'h00FD);
    tv[13] = v(0, 16'h0000, 16'hFF00, 16'h00FD);
    tv[14] = v(0, 16'h0000, 16'hFF00, 16'h00FD);
    tv[15] = v(0, 16'h0000, 16'hFF02, 16'h00FD);
    tv[16] = v(0, 16'h0000, 16'hFF00, 16'h00FD);
    tv[17] = v(0, 16'h0000, 16'hFF00, 16'h00FD);
    tv[18] = v(0, 16'h0000, 16'hFF00, 16'h00FD);
    tv[19] = v(0, 16'h0000, 16'hFF00, 16'h00FF);
    tv[20] = v(0, 16'h0000, 16'hFF04, 16'h00FB);
    tv[21] = v(0, 16'h0004, 16'hFF00, 16'h00FB);
    tv[22] = v(0, 16'h0000, 16'hFF00, 16'h00FF);

    for (int i = 0; i < 23; i++) begin
      rst = tv[i].rst; sleep = tv[i].slp; deepslp = tv[i].dsl;
      @(posedge clk); #1;
      chk($sformatf("mpr_vec%0d", i), {48'b0, mpr}, {48'b0, tv[i].exp_mpr});
      chk($sformatf("rdata_vec%0d", i), rdata, 64'h0);
    end
    sleep = '0; deepslp = 16'hFF00;
    acc_m[0] = 8'hFF;

    // line writes and read-back on packet 0
    for (int i = 0; i < 50; i++) op(1, 0, 0, AW'(i), {$urandom, $urandom});
    for (int i = 0; i < 50; i++) op(0, 1, 0, AW'(i), 64'h0);
    chk("mpr_s1", {48'b0, mpr}, 64'h00FF);

    // packet 0 asleep: writes dropped, reads hold
    deepslp = 16'h00FF; acc_m[0] = 8'h00;
    op(1, 0, 0, AW'(0), {$urandom, $urandom});
    chk("mpr0_fall", {56'b0, mpr[0]}, 64'h0);
    for (int i = 1; i < 50; i++) op(1, 0, 0, AW'(i), {$urandom, $urandom});
    for (int i = 0; i < 50; i++) op(0, 1, 0, AW'(i), 64'h0);
    chk("mpr_s2", {48'b0, mpr}, 64'hFF00);

    // release: rdata holds for the wake time, then shows retained line
    deepslp = 16'h0000;
    for (int i = 0; i < 4; i++) op(0, 1, 0, AW'(0), 64'h0);
    acc_m[0] = 8'hFF;
    op(0, 1, 0, AW'(0), 64'h0);
    op(0, 1, 0, AW'(7), 64'h0);
    chk("mpr_s3", {48'b0, mpr}, 64'hFFFF);

    // byte mode: lane 3 row 7 only, upper write bits ignored
    op(1, 0, 1, {3'd3, 8'd7}, {56'hDEAD_BEEF_1234_56, 8'hA5});
    op(0, 1, 0, AW'(7), 64'h0);
    op(0, 1, 0, AW'(6), 64'h0);

    // one-cycle shutoff on bank (0,2): lane 2 contents lost
    shutoff = 16'h0004; acc_m[0] = 8'hFB;
    for (int r = 0; r < D; r++) mv[0][2][r] = 1'b0;
    op(0, 1, 0, AW'(7), 64'h0);
    shutoff = 16'h0000;
    for (int i = 1; i <= 4; i++) op(0, 1, 0, AW'(i), 64'h0);
    acc_m[0] = 8'hFF;
    for (int i = 0; i < 10; i++) op(0, 1, 0, AW'(i), 64'h0);
    chk("mpr_s5", {48'b0, mpr}, 64'hFFFF);

    // user 2 and 3 hit packet 1; packet 0 untouched
    usr_cfg.user_id = 8'd2; acc_m[1] = 8'hFF;
    for (int i = 0; i < 10; i++) op(1, 0, 0, AW'(i), {$urandom, $urandom});
    op(1, 1, 0, AW'(20), {$urandom, $urandom});
    for (int i = 0; i < 10; i++) op(0, 1, 0, AW'(i), 64'h0);
    op(0, 1, 0, AW'(20), 64'h0);
    usr_cfg.user_id = 8'd3;
    op(0, 1, 0, AW'(5), 64'h0);
    usr_cfg.user_id = 8'd0;
    for (int i = 0; i < 10; i++) op(0, 1, 0, AW'(i), 64'h0);
    op(0, 1, 0, AW'(49), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kv_cache_pkt_mem.md
# kv_cache_pkt_mem

KV-cache storage block holding `CACHE_PKT_NUM` packets, each packet a row of `CACHE_NUM` single-port SRAM banks (one byte lane per bank) of depth `CACHE_DEPTH`. The active user in `usr_cfg` selects one packet for all reads and writes. Per-bank power controls (sleep, deep sleep, shut-off) gate access and report readiness on `mpr`. The block sits between the core's KV write/read path and the per-user cache macros.

## Interface
- `IDATA_WIDTH`, 64: write word width, `CACHE_NUM` lanes × `LANE_W` bits.
- `ODATA_BIT`, 64: read word width; equals `IDATA_WIDTH`.
- `CACHE_NUM`, 8: banks (byte lanes) per packet; `LANE_W = IDATA_WIDTH/CACHE_NUM`.
- `CACHE_PKT_NUM`, 2: packets; must divide `USER_NUM`.
- `CACHE_DEPTH`, 256: rows per bank; `ROW_W = clog2(CACHE_DEPTH)`.
- `CACHE_ADDR_WIDTH`, `clog2(CACHE_NUM)+ROW_W`: address width.
- `USER_NUM`, 4: users; packet index = `user_id / (USER_NUM/CACHE_PKT_NUM)`.
- `WAKE_SLEEP`, 1: cycles from `sleep` release to ready.
- `WAKE_DEEP`, 4: cycles from `deepslp`/`shutoff` release to ready.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cache_addr` in `CACHE_ADDR_WIDTH`: `[ROW_W-1:0]` = row; `[CACHE_ADDR_WIDTH-1:ROW_W]` = lane (byte mode only).
- `cache_ren` in 1: read strobe.
- `cache_rdata` out `ODATA_BIT`: registered read data, full line.
- `cache_wen` in 1: write strobe.
- `cache_wdata` in `IDATA_WIDTH`: write data.
- `cache_wdata_byte_flag` in 1: 0 = whole line; 1 = single lane from `cache_wdata[LANE_W-1:0]`.
- `usr_cfg` in `USER_CONFIG` struct: only `user_id` used; `user_token_cnt`, `user_kv_cache_not_full`, `user_first_token_flag` ignored.
- `sleep`, `deepslp`, `shutoff` in `[CACHE_PKT_NUM][CACHE_NUM]`: per-bank power requests.
- `bc1`, `bc2` in 1: macro bias controls; passed to macros, no functional effect.
- `mpr` out `[CACHE_PKT_NUM][CACHE_NUM]`: per-bank power-ready (1 = accessible).

## Operation
- Selected packet `P` comes from `usr_cfg.user_id`; with defaults, users 0/1 use packet 0 and users 2/3 use packet 1. Unselected packets are never accessed.
- Bank `(p,b)` is accessible iff `mpr[p][b]=1`.
- Write, line mode: each accessible bank `b` of `P` stores `cache_wdata[b*LANE_W +: LANE_W]` at the row. Inaccessible banks drop their lane.
- Write, byte mode: only bank `lane` of `P` is written, if accessible.
- Read (`cache_ren=1`, `cache_wen=0`): each accessible bank of `P` loads its row into its lane of `cache_rdata`. Lanes of inaccessible banks keep their previous value.
- `cache_wen` and `cache_ren` together: the write executes, the read is ignored, and `cache_rdata` holds.
- `sleep` and `deepslp` retain contents.
- `shutoff` loses contents. Each bank keeps a per-row valid bit, cleared while `shutoff` is asserted and set on a write. Reads of invalid rows return 0.
- Power request per bank: `lp = sleep|deepslp|shutoff`.
  - `lp=1`: `mpr=0` from the next edge, and access is blocked in the same cycle.
  - `lp=0`: a per-bank counter counts up. `mpr` rises after `WAKE_DEEP` cycles (`WAKE_SLEEP` if only `sleep` was the last request).

## Timing
- Reset: `cache_rdata=0`, `mpr=0`, wake counters=0, all row valid bits=0. Banks become ready `WAKE_DEEP` cycles after `rst` falls, provided `lp=0`.
- Read latency 1: inputs sampled at edge N; `cache_rdata` updated after edge N and held until the next read.
- Write takes effect at the sampling edge; a read at edge N+1 returns the new data.
- Power request toggling mid-count restarts the wake counter.
- Power requests during `rst` are ignored; `mpr` stays 0.

## Test plan
- Reset, idle 10 cycles, `user_id=0`, `deepslp[1]=all`. Write 50 random 64-bit lines at addrs 0..49, then read 0..49. Each `cache_rdata` equals the written data one cycle after `ren`. `mpr[0]=8'hFF`, `mpr[1]=0`.
- Set `deepslp[0]=all`, `deepslp[1]=0`. Write new data to 0..49, then read. `cache_rdata` is unchanged throughout, and `mpr[0]` falls to 0 one cycle after the request.
- Release `deepslp[0]` and read addr 0 every cycle. `cache_rdata` stays constant for `WAKE_DEEP` cycles, then returns the line written in the first scenario (data retained, no write while asleep).
- Byte mode: write `8'hA5` to lane 3 row 7 (addr `3<<8|7`). Reading row 7 changes only byte 3.
- Assert `shutoff[0][2]` for 1 cycle, then wait `WAKE_DEEP`. Reading previously written rows returns byte 2 = 0 and the other lanes intact.
- `user_id=2`: writes and reads hit packet 1 only, and packet 0 data is unchanged afterwards.
